envm_pattern_fault_store: RTL and testbench
===========================================

ENVM_PATTERN_FAULT_STORE -- requirements
Module: envm_pattern_fault_store

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 8, giving the PE array side N.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 8, giving the weight pattern width.
REQ-003 SHALL have parameter ACTIVATION_WIDTH, default 8, giving the activation pattern width.
REQ-004 SHALL have parameter PARTIAL_SUM_WIDTH, default WEIGHT_WIDTH+ACTIVATION_WIDTH+clog2(N), giving the answer width.
REQ-005 SHALL have parameter NUM_TEST_TYPES, default 2 (0=SA, 1=TD), giving the number of pattern banks T.
REQ-006 SHALL have parameter PATTERN_DEPTH, default 18, giving entries per bank D.
REQ-007 SHALL have derived widths AW=clog2(N), PW=clog2(D), TW=max(1,clog2(T)), CW=clog2(N*N+1).
REQ-008 Ports, one per line (name  direction  width  meaning); clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, rising edge.
- rst_n  in  1  async active-low reset.
- pat_wr_en  in  1  pattern write strobe.
- pat_wr_type  in  TW  bank to write.
- pat_wr_addr  in  PW  entry to write.
- pat_wr_weight / pat_wr_act / pat_wr_ans  in  WEIGHT_WIDTH / ACTIVATION_WIDTH / PARTIAL_SUM_WIDTH  entry data.
- pat_wr_err  out  1  one-cycle pulse: write rejected.
- stream_start  in  1  start pulse for a pattern stream.
- stream_type  in  TW  bank to stream.
- stream_ready  in  1  consumer ready.
- stream_valid  out  1  pattern output valid.
- stream_index  out  PW  index of presented pattern.
- Scan_data_weight / Scan_data_activation / Scan_data_answer  out  widths as above  presented pattern.
- stream_last  out  1  presented pattern is entry D-1.
- stream_busy  out  1  streamer not IDLE.
- detection_en  in  1  fault-record strobe.
- detection_merge  in  1  0 overwrite row, 1 OR-accumulate.
- detection_addr  in  AW  row index.
- single_pe_detection  in  N  per-PE fault bits for that row.
- row_fault_detection / column_fault_detection  in  1 / 1  row/column flag at detection_addr.
- fault_clear  in  1  synchronous clear of all fault state.
- envm_faulty_patterns_flat  out  N*N  fault map, row i at bits [i*N +: N].
- faulty_row_flat / faulty_column_flat  out  N / N  row/column flags.
- fault_count  out  CW  number of set bits in fault map.

Function
REQ-009 Pattern write SHALL store to bank pat_wr_type, entry pat_wr_addr on the clk edge when pat_wr_en=1, type<T, addr<D, and not (stream_busy and type=stream bank).
REQ-010 A write failing REQ-009 SHALL not modify memory and SHALL pulse pat_wr_err for one cycle after the edge.
REQ-011 Streamer SHALL have states IDLE, PRESENT, DONE.
REQ-012 IDLE->PRESENT on stream_start with stream_type<T; index<=0; bank latched; stream_valid=1 the next cycle (latency 1).
REQ-013 stream_start with stream_type>=T, or while not IDLE, SHALL be ignored.
REQ-014 In PRESENT, index, data and stream_valid SHALL hold until stream_valid&stream_ready; index then increments.
REQ-015 Handshake on index D-1 (stream_last=1) SHALL move PRESENT->DONE; DONE->IDLE after one cycle with stream_valid=0.
REQ-016 Scan_data_* SHALL be the latched bank's entry at stream_index, registered; 0 when stream_valid=0.
REQ-017 On detection_en with detection_addr<N: row, row flag and column flag SHALL be written, replaced if merge=0, ORed if merge=1.
REQ-018 detection_addr>=N SHALL be ignored.
REQ-019 fault_count SHALL equal popcount of the fault map, updated the cycle after the map changes.
REQ-020 fault_clear SHALL zero map, flags and count; it SHALL win over a same-cycle detection_en.
REQ-021 Pattern and fault paths SHALL operate independently and concurrently.

Reset
REQ-022 rst_n=0 SHALL force streamer to IDLE and set stream_valid, stream_busy, stream_last, stream_index, Scan_data_*, pat_wr_err, fault map, flags and fault_count to 0.
REQ-023 Pattern memory contents SHALL NOT be reset.
REQ-024 Reset mid-stream SHALL abort the stream with no further valid beats after release.

Verification
REQ-025 Load bank 1 entries 0..17 with weight=i, act=i+1, ans=2i; start type 1, ready=1 -> 18 beats, index 0..17, last only on 17, busy drops 2 cycles after beat 17.
REQ-026 Stream with ready toggled every other cycle -> each beat holds data stable until accepted; no skipped or duplicated index.
REQ-027 Write bank 1 addr 3 mid-stream of bank 1 -> pat_wr_err pulse, data unchanged; same write to bank 0 -> accepted.
REQ-028 Detect row 2 = 0x81 (overwrite), then 0x10 (merge) -> row 2 = 0x91, fault_count=3; detect row 2 = 0x01 (overwrite) -> fault_count=1.
REQ-029 fault_clear with detection_en on row 5 = 0xFF same cycle -> map all zero, fault_count=0.
REQ-030 Assert rst_n=0 at stream beat 5 -> all outputs 0 immediately; after release no valid until a new stream_start; previously loaded patterns still read back.

Source files
------------

// File: rtl/envm_pattern_fault_store_if.sv
// Bus bundle for envm_pattern_fault_store.
// Groups the pattern-write port, the pattern streamer handshake and the
// fault-detection/fault-map signals. clk and rst_n stay outside the bundle.
//   master : the side that loads patterns, consumes the stream and reports faults
//   slave  : the pattern/fault store itself
interface envm_pattern_fault_store_if #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
  parameter int NUM_TEST_TYPES    = 2,
  parameter int PATTERN_DEPTH     = 18
);
  localparam int N  = SYSTOLIC_SIZE;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (PATTERN_DEPTH > 1) ? $clog2(PATTERN_DEPTH) : 1;
  localparam int TW = (NUM_TEST_TYPES > 1) ? $clog2(NUM_TEST_TYPES) : 1;
  localparam int CW = $clog2(N * N + 1);

  // pattern write port
  logic                         pat_wr_en;
  logic [TW-1:0]                pat_wr_type;
  logic [PW-1:0]                pat_wr_addr;
  logic [WEIGHT_WIDTH-1:0]      pat_wr_weight;
  logic [ACTIVATION_WIDTH-1:0]  pat_wr_act;
  logic [PARTIAL_SUM_WIDTH-1:0] pat_wr_ans;
  logic                         pat_wr_err;

  // pattern streamer
  logic                         stream_start;
  logic [TW-1:0]                stream_type;
  logic                         stream_ready;
  logic                         stream_valid;
  logic [PW-1:0]                stream_index;
  logic [WEIGHT_WIDTH-1:0]      Scan_data_weight;
  logic [ACTIVATION_WIDTH-1:0]  Scan_data_activation;
  logic [PARTIAL_SUM_WIDTH-1:0] Scan_data_answer;
  logic                         stream_last;
  logic                         stream_busy;

  // fault recording
  logic                         detection_en;
  logic                         detection_merge;
  logic [AW-1:0]                detection_addr;
  logic [N-1:0]                 single_pe_detection;
  logic                         row_fault_detection;
  logic                         column_fault_detection;
  logic                         fault_clear;
  logic [N*N-1:0]               envm_faulty_patterns_flat;
  logic [N-1:0]                 faulty_row_flat;
  logic [N-1:0]                 faulty_column_flat;
  logic [CW-1:0]                fault_count;

  modport master (
    output pat_wr_en, pat_wr_type, pat_wr_addr, pat_wr_weight, pat_wr_act, pat_wr_ans,
    input  pat_wr_err,
    output stream_start, stream_type, stream_ready,
    input  stream_valid, stream_index, Scan_data_weight, Scan_data_activation,
           Scan_data_answer, stream_last, stream_busy,
    output detection_en, detection_merge, detection_addr, single_pe_detection,
           row_fault_detection, column_fault_detection, fault_clear,
    input  envm_faulty_patterns_flat, faulty_row_flat, faulty_column_flat, fault_count
  );

  modport slave (
    input  pat_wr_en, pat_wr_type, pat_wr_addr, pat_wr_weight, pat_wr_act, pat_wr_ans,
    output pat_wr_err,
    input  stream_start, stream_type, stream_ready,
    output stream_valid, stream_index, Scan_data_weight, Scan_data_activation,
           Scan_data_answer, stream_last, stream_busy,
    input  detection_en, detection_merge, detection_addr, single_pe_detection,
           row_fault_detection, column_fault_detection, fault_clear,
    output envm_faulty_patterns_flat, faulty_row_flat, faulty_column_flat, fault_count
  );
endinterface

// File: rtl/envm_pattern_fault_store.sv
// envm_pattern_fault_store
// Holds test patterns (weight, activation, expected answer) for a systolic
// PE array in NUM_TEST_TYPES banks of PATTERN_DEPTH entries, streams a bank
// out over a valid/ready handshake, and independently records a per-PE
// fault map with row/column flags and a running popcount.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : envm_pattern_fault_store_if.slave (pattern write, stream, fault map)
module envm_pattern_fault_store #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
  parameter int NUM_TEST_TYPES    = 2,
  parameter int PATTERN_DEPTH     = 18
) (
  input  logic clk,
  input  logic rst_n,
  envm_pattern_fault_store_if.slave bus
);
  localparam int N  = SYSTOLIC_SIZE;
  localparam int T  = NUM_TEST_TYPES;
  localparam int D  = PATTERN_DEPTH;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int TW = (T > 1) ? $clog2(T) : 1;
  localparam int CW = $clog2(N * N + 1);
  localparam int RW = $clog2(N + 1);
  localparam int MW = (T * D > 1) ? $clog2(T * D) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_PRESENT, ST_DONE} state_t;

  // ---------------------------------------------------------------------
  // Pattern memory: all banks share one flat array per field, entry
  // (bank, idx) lives at bank*D + idx. Contents survive reset.
  // ---------------------------------------------------------------------
  logic [WEIGHT_WIDTH-1:0]      mem_weight [T*D];
  logic [ACTIVATION_WIDTH-1:0]  mem_act    [T*D];
  logic [PARTIAL_SUM_WIDTH-1:0] mem_ans    [T*D];

  state_t        state_reg;
  logic [TW-1:0] bank_reg;
  logic [PW-1:0] index_reg;
  logic          valid_reg;
  logic          last_reg;
  logic          busy_reg;
  logic          wr_err_reg;

  logic          wr_ok;
  logic [MW-1:0] wr_addr;

  // The bank currently being streamed is write-protected so presented
  // data cannot change underneath a stalled beat.
  always_comb begin
    wr_ok   = (int'(bus.pat_wr_type) < T) && (int'(bus.pat_wr_addr) < D) &&
              !(busy_reg && (bus.pat_wr_type == bank_reg));
    wr_addr = MW'(int'(bus.pat_wr_type) * D + int'(bus.pat_wr_addr));
  end

  always_ff @(posedge clk) begin
    if (bus.pat_wr_en && wr_ok) begin
      mem_weight[wr_addr] <= bus.pat_wr_weight;
      mem_act[wr_addr]    <= bus.pat_wr_act;
      mem_ans[wr_addr]    <= bus.pat_wr_ans;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_err_reg <= 1'b0;
    else        wr_err_reg <= bus.pat_wr_en && !wr_ok;
  end

  // ---------------------------------------------------------------------
  // Read address is the entry that will be presented after this edge:
  // entry 0 of the requested bank on start, index+1 on an accepted beat,
  // otherwise the current entry so a stalled beat re-reads the same word.
  // ---------------------------------------------------------------------
  int            rd_bank;
  int            rd_entry;
  logic [MW-1:0] rd_addr;

  always_comb begin
    rd_bank  = int'(bank_reg);
    rd_entry = int'(index_reg);
    case (state_reg)
      ST_IDLE: begin
        rd_bank  = (int'(bus.stream_type) < T) ? int'(bus.stream_type) : 0;
        rd_entry = 0;
      end
      ST_PRESENT: begin
        if (bus.stream_ready && !last_reg) rd_entry = int'(index_reg) + 1;
      end
      default: ;
    endcase
    rd_addr = MW'(rd_bank * D + rd_entry);
  end

  logic [WEIGHT_WIDTH-1:0]      rd_weight_reg;
  logic [ACTIVATION_WIDTH-1:0]  rd_act_reg;
  logic [PARTIAL_SUM_WIDTH-1:0] rd_ans_reg;

  always_ff @(posedge clk) begin
    rd_weight_reg <= mem_weight[rd_addr];
    rd_act_reg    <= mem_act[rd_addr];
    rd_ans_reg    <= mem_ans[rd_addr];
  end

  // ---------------------------------------------------------------------
  // Streamer FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      bank_reg  <= '0;
      index_reg <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.stream_start && (int'(bus.stream_type) < T)) begin
            state_reg <= ST_PRESENT;
            bank_reg  <= bus.stream_type;
            index_reg <= '0;
            valid_reg <= 1'b1;
            last_reg  <= (D == 1);
            busy_reg  <= 1'b1;
          end
        end
        ST_PRESENT: begin
          if (valid_reg && bus.stream_ready) begin
            if (last_reg) begin
              state_reg <= ST_DONE;
              valid_reg <= 1'b0;
              last_reg  <= 1'b0;
            end else begin
              index_reg <= index_reg + PW'(1);
              last_reg  <= (int'(index_reg) + 1 == D - 1);
            end
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.pat_wr_err           = wr_err_reg;
  assign bus.stream_valid         = valid_reg;
  assign bus.stream_index         = index_reg;
  assign bus.stream_last          = last_reg;
  assign bus.stream_busy          = busy_reg;
  // Read registers are not reset; valid gating gives zero outside a beat.
  assign bus.Scan_data_weight     = valid_reg ? rd_weight_reg : '0;
  assign bus.Scan_data_activation = valid_reg ? rd_act_reg    : '0;
  assign bus.Scan_data_answer     = valid_reg ? rd_ans_reg    : '0;

  // ---------------------------------------------------------------------
  // Fault map and row/column flags
  // ---------------------------------------------------------------------
  logic [N-1:0][N-1:0] map_reg;
  logic [N-1:0]        row_flag_reg;
  logic [N-1:0]        col_flag_reg;
  logic [CW-1:0]       fault_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_reg      <= '0;
      row_flag_reg <= '0;
      col_flag_reg <= '0;
    end else if (bus.fault_clear) begin
      map_reg      <= '0;
      row_flag_reg <= '0;
      col_flag_reg <= '0;
    end else if (bus.detection_en && (int'(bus.detection_addr) < N)) begin
      if (bus.detection_merge) begin
        map_reg[bus.detection_addr]      <= map_reg[bus.detection_addr] | bus.single_pe_detection;
        row_flag_reg[bus.detection_addr] <= row_flag_reg[bus.detection_addr] | bus.row_fault_detection;
        col_flag_reg[bus.detection_addr] <= col_flag_reg[bus.detection_addr] | bus.column_fault_detection;
      end else begin
        map_reg[bus.detection_addr]      <= bus.single_pe_detection;
        row_flag_reg[bus.detection_addr] <= bus.row_fault_detection;
        col_flag_reg[bus.detection_addr] <= bus.column_fault_detection;
      end
    end
  end

  // Per-row popcounts, summed into the registered total.
  logic [N-1:0][RW-1:0] row_pop;
  logic [CW-1:0]        pop_sum;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_row_pop
      assign row_pop[gi] = RW'($countones(map_reg[gi]));
    end
  endgenerate

  always_comb begin
    pop_sum = '0;
    for (int i = 0; i < N; i++) pop_sum = pop_sum + CW'(row_pop[i]);
  end

  // Count tracks the map one cycle late; clear zeroes it on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               fault_count_reg <= '0;
    else if (bus.fault_clear) fault_count_reg <= '0;
    else                      fault_count_reg <= pop_sum;
  end

  assign bus.envm_faulty_patterns_flat = map_reg;
  assign bus.faulty_row_flat           = row_flag_reg;
  assign bus.faulty_column_flat        = col_flag_reg;
  assign bus.fault_count               = fault_count_reg;
endmodule

// File: tb/tb_envm_pattern_fault_store.sv
// Directed testbench for envm_pattern_fault_store.
module tb_envm_pattern_fault_store;
  localparam int N   = 8;
  localparam int WW  = 8;
  localparam int AWD = 8;
  localparam int PSW = 19;
  localparam int T   = 2;
  localparam int D   = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  envm_pattern_fault_store_if #(
    .SYSTOLIC_SIZE(N), .WEIGHT_WIDTH(WW), .ACTIVATION_WIDTH(AWD),
    .PARTIAL_SUM_WIDTH(PSW), .NUM_TEST_TYPES(T), .PATTERN_DEPTH(D)
  ) bus ();

  envm_pattern_fault_store #(
    .SYSTOLIC_SIZE(N), .WEIGHT_WIDTH(WW), .ACTIVATION_WIDTH(AWD),
    .PARTIAL_SUM_WIDTH(PSW), .NUM_TEST_TYPES(T), .PATTERN_DEPTH(D)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int passed = 0;

  // bench-side model of pattern memory
  logic [WW-1:0]  exp_w [T][D];
  logic [AWD-1:0] exp_a [T][D];
  logic [PSW-1:0] exp_s [T][D];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pat_wr_en = 0; bus.pat_wr_type = '0; bus.pat_wr_addr = '0;
    bus.pat_wr_weight = '0; bus.pat_wr_act = '0; bus.pat_wr_ans = '0;
    bus.stream_start = 0; bus.stream_type = '0; bus.stream_ready = 0;
    bus.detection_en = 0; bus.detection_merge = 0; bus.detection_addr = '0;
    bus.single_pe_detection = '0; bus.row_fault_detection = 0;
    bus.column_fault_detection = 0; bus.fault_clear = 0;
  endtask

  // {valid, index, last, weight, act, ans}
  function automatic logic [41:0] obs();
    return {bus.stream_valid, bus.stream_index, bus.stream_last,
            bus.Scan_data_weight, bus.Scan_data_activation, bus.Scan_data_answer};
  endfunction

  function automatic logic [41:0] exp_beat(int b, int i);
    return {1'b1, 5'(i), (i == D - 1), exp_w[b][i], exp_a[b][i], exp_s[b][i]};
  endfunction

  task automatic write_pat(input int ty, input int ad, input logic [WW-1:0] w,
                           input logic [AWD-1:0] a, input logic [PSW-1:0] s, input bit accept);
    bus.pat_wr_en = 1; bus.pat_wr_type = 1'(ty); bus.pat_wr_addr = 5'(ad);
    bus.pat_wr_weight = w; bus.pat_wr_act = a; bus.pat_wr_ans = s;
    tick();
    bus.pat_wr_en = 0;
    if (accept) begin
      exp_w[ty][ad] = w; exp_a[ty][ad] = a; exp_s[ty][ad] = s;
    end
  endtask

  task automatic start_stream(input int ty);
    bus.stream_ready = 0; bus.stream_start = 1; bus.stream_type = 1'(ty);
    tick();
    bus.stream_start = 0;
  endtask

  task automatic detect(input int row, input logic [7:0] bits, input bit merge,
                        input bit rf, input bit cf);
    bus.detection_en = 1; bus.detection_merge = merge; bus.detection_addr = 3'(row);
    bus.single_pe_detection = bits; bus.row_fault_detection = rf; bus.column_fault_detection = cf;
    tick();
    bus.detection_en = 0;
  endtask

  task automatic test_reset();
    logic [45:0] got;
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    got = {bus.stream_valid, bus.stream_busy, bus.stream_last, bus.pat_wr_err,
           bus.stream_index, bus.fault_count, bus.faulty_row_flat, bus.faulty_column_flat,
           bus.Scan_data_weight, 8'h00};
    checks++;
    if (got !== '0) $display("FAIL reset_outputs: got %h expected 0", got);
    else passed++;
    checks++;
    if (bus.envm_faulty_patterns_flat !== 64'h0)
      $display("FAIL reset_map: got %h expected 0", bus.envm_faulty_patterns_flat);
    else passed++;
    rst_n = 1;
    tick();
  endtask

  task automatic test_load();
    int errs = 0;
    for (int i = 0; i < D; i++) begin
      write_pat(1, i, 8'(i), 8'(i + 1), 19'(2 * i), 1);
      if (bus.pat_wr_err !== 1'b0) errs++;
      write_pat(0, i, 8'(8'h40 + i), 8'(8'h80 + i), 19'(19'h100 + i), 1);
      if (bus.pat_wr_err !== 1'b0) errs++;
    end
    checks++;
    if (errs != 0) $display("FAIL load_no_err: got %0d error pulses expected 0", errs);
    else passed++;
  endtask

  task automatic test_stream_full();
    start_stream(1);
    bus.stream_ready = 1;
    for (int b = 0; b < D; b++) begin
      checks++;
      if (obs() !== exp_beat(1, b))
        $display("FAIL full_beat%0d: got %h expected %h", b, obs(), exp_beat(1, b));
      else passed++;
      tick();
    end
    bus.stream_ready = 0;
    checks++;
    if ({bus.stream_valid, bus.stream_busy, bus.stream_last} !== 3'b010)
      $display("FAIL full_done_state: got v/b/l=%b expected 010",
               {bus.stream_valid, bus.stream_busy, bus.stream_last});
    else passed++;
    tick();
    checks++;
    if ({bus.stream_valid, bus.stream_busy} !== 2'b00)
      $display("FAIL full_busy_drop: got v/b=%b expected 00", {bus.stream_valid, bus.stream_busy});
    else passed++;
  endtask

  task automatic test_ready_toggle();
    int  exp_idx = 0;
    bit  done = 0;
    int  bad = 0;
    start_stream(1);
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (bus.stream_valid) begin
        if (exp_idx >= D || obs() !== exp_beat(1, exp_idx)) begin
          $display("FAIL toggle_beat: got %h expected index %0d", obs(), exp_idx);
          bad++;
        end
      end else if (!bus.stream_busy) begin
        done = 1;
      end
      if (!done) begin
        bus.stream_ready = cyc[0];
        if (bus.stream_valid && bus.stream_ready) exp_idx++;
        tick();
      end
    end
    bus.stream_ready = 0;
    checks++;
    if (bad != 0) $display("FAIL toggle_data: got %0d bad beats expected 0", bad);
    else passed++;
    checks++;
    if (!done || exp_idx != D)
      $display("FAIL toggle_count: got %0d beats done=%0d expected %0d", exp_idx, done, D);
    else passed++;
  endtask

  task automatic test_stream_readback(input int bank);
    int beats = 0;
    int bad = 0;
    start_stream(bank);
    bus.stream_ready = 1;
    for (int cyc = 0; cyc < 40 && bus.stream_busy; cyc++) begin
      if (bus.stream_valid) begin
        if (beats >= D || obs() !== exp_beat(bank, beats)) begin
          $display("FAIL readback_bank%0d: got %h expected index %0d", bank, obs(), beats);
          bad++;
        end
        beats++;
      end
      tick();
    end
    bus.stream_ready = 0;
    checks++;
    if (bad != 0 || beats != D || bus.stream_busy)
      $display("FAIL readback_bank%0d_summary: got %0d beats %0d bad expected %0d beats 0 bad",
               bank, beats, bad, D);
    else passed++;
  endtask

  task automatic test_write_conflict();
    start_stream(1);
    write_pat(1, 3, 8'hAA, 8'hBB, 19'h1234, 0);
    checks++;
    if (bus.pat_wr_err !== 1'b1) $display("FAIL conflict_err: got %b expected 1", bus.pat_wr_err);
    else passed++;
    tick();
    checks++;
    if (bus.pat_wr_err !== 1'b0) $display("FAIL conflict_err_pulse: got %b expected 0", bus.pat_wr_err);
    else passed++;
    write_pat(0, 3, 8'h55, 8'h66, 19'h777, 1);
    checks++;
    if (bus.pat_wr_err !== 1'b0) $display("FAIL other_bank_err: got %b expected 0", bus.pat_wr_err);
    else passed++;
    write_pat(0, 18, 8'hEE, 8'hEE, 19'h0EEE, 0);
    checks++;
    if (bus.pat_wr_err !== 1'b1) $display("FAIL addr_range_err: got %b expected 1", bus.pat_wr_err);
    else passed++;
    // drain the bank-1 stream already in progress, then read both banks back
    bus.stream_ready = 1;
    for (int cyc = 0; cyc < 40 && bus.stream_busy; cyc++) tick();
    bus.stream_ready = 0;
    test_stream_readback(1);
    test_stream_readback(0);
  endtask

  task automatic test_detection();
    detect(2, 8'h81, 0, 1, 0);
    checks++;
    if (bus.envm_faulty_patterns_flat[16 +: 8] !== 8'h81 || bus.fault_count !== 7'd0)
      $display("FAIL det_overwrite: got row2=%h count=%0d expected 81 0",
               bus.envm_faulty_patterns_flat[16 +: 8], bus.fault_count);
    else passed++;
    tick();
    checks++;
    if (bus.fault_count !== 7'd2) $display("FAIL det_count2: got %0d expected 2", bus.fault_count);
    else passed++;
    detect(2, 8'h10, 1, 0, 1);
    tick();
    checks++;
    if ({bus.envm_faulty_patterns_flat[16 +: 8], bus.fault_count, bus.faulty_row_flat, bus.faulty_column_flat}
        !== {8'h91, 7'd3, 8'h04, 8'h04})
      $display("FAIL det_merge: got row2=%h count=%0d rows=%h cols=%h expected 91 3 04 04",
               bus.envm_faulty_patterns_flat[16 +: 8], bus.fault_count,
               bus.faulty_row_flat, bus.faulty_column_flat);
    else passed++;
    detect(2, 8'h01, 0, 0, 0);
    tick();
    checks++;
    if ({bus.envm_faulty_patterns_flat[16 +: 8], bus.fault_count, bus.faulty_row_flat}
        !== {8'h01, 7'd1, 8'h00})
      $display("FAIL det_overwrite2: got row2=%h count=%0d rows=%h expected 01 1 00",
               bus.envm_faulty_patterns_flat[16 +: 8], bus.fault_count, bus.faulty_row_flat);
    else passed++;
    detect(7, 8'hF0, 1, 1, 1);
    tick();
    checks++;
    if ({bus.envm_faulty_patterns_flat[56 +: 8], bus.fault_count, bus.faulty_column_flat}
        !== {8'hF0, 7'd5, 8'h80})
      $display("FAIL det_row7: got row7=%h count=%0d cols=%h expected F0 5 80",
               bus.envm_faulty_patterns_flat[56 +: 8], bus.fault_count, bus.faulty_column_flat);
    else passed++;
  endtask

  task automatic test_clear();
    bus.fault_clear = 1;
    detect(5, 8'hFF, 0, 1, 1);
    bus.fault_clear = 0;
    checks++;
    if ({bus.envm_faulty_patterns_flat, bus.fault_count, bus.faulty_row_flat, bus.faulty_column_flat} !== '0)
      $display("FAIL clear_wins: got map=%h count=%0d rows=%h cols=%h expected all 0",
               bus.envm_faulty_patterns_flat, bus.fault_count, bus.faulty_row_flat, bus.faulty_column_flat);
    else passed++;
    tick();
    checks++;
    if (bus.fault_count !== 7'd0) $display("FAIL clear_count: got %0d expected 0", bus.fault_count);
    else passed++;
  endtask

  task automatic test_reset_midstream();
    logic [41:0] got;
    int stray = 0;
    detect(1, 8'h0F, 0, 1, 0);
    tick();
    start_stream(1);
    bus.stream_ready = 1;
    repeat (5) tick();
    checks++;
    if (obs() !== exp_beat(1, 5)) $display("FAIL mid_beat5: got %h expected %h", obs(), exp_beat(1, 5));
    else passed++;
    rst_n = 0;
    #1;
    got = {bus.stream_valid, bus.stream_busy, bus.stream_last, bus.pat_wr_err, bus.stream_index,
           bus.Scan_data_weight, bus.Scan_data_activation, bus.fault_count, bus.faulty_row_flat};
    checks++;
    if (got !== '0 || bus.envm_faulty_patterns_flat !== 64'h0 || bus.Scan_data_answer !== '0)
      $display("FAIL mid_reset_outputs: got %h map=%h expected 0", got, bus.envm_faulty_patterns_flat);
    else passed++;
    tick(); tick();
    rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.stream_valid !== 1'b0 || bus.stream_busy !== 1'b0) stray++;
    end
    bus.stream_ready = 0;
    checks++;
    if (stray != 0) $display("FAIL mid_no_valid: got %0d active cycles expected 0", stray);
    else passed++;
    start_stream(1);
    checks++;
    if (obs() !== exp_beat(1, 0)) $display("FAIL mid_restart_beat0: got %h expected %h", obs(), exp_beat(1, 0));
    else passed++;
    bus.stream_ready = 1;
    repeat (5) tick();
    checks++;
    if (obs() !== exp_beat(1, 5)) $display("FAIL mid_restart_beat5: got %h expected %h", obs(), exp_beat(1, 5));
    else passed++;
    bus.stream_ready = 1;
    for (int cyc = 0; cyc < 40 && bus.stream_busy; cyc++) tick();
    bus.stream_ready = 0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_stream_full();
    test_ready_toggle();
    test_write_conflict();
    test_detection();
    test_clear();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
